// File: rtl/pipe_pkg.sv
// Shared constants and types for the Y86-64 pipeline control unit.
package pipe_pkg;

   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_HALTED,
      ST_FAULT
   } pc_state_e;

   function automatic logic is_exc(input logic [2:0] s);
      return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
   endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// 32-bit saturating event counter used for pipeline performance statistics.
module pipe_sat_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_inc,
   output logic [31:0] o_cnt
);

   logic [31:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != 32'hFFFF_FFFF)) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 stall/bubble control with post-reset flush and run/halt/fault FSM.
// Define PIPE_CTRL_PERF_EN to build the saturating performance counters.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int INIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  E_dstM,
   input  logic        e_Cnd,
   input  logic [3:0]  M_icode,
   input  logic [2:0]  m_stat,
   input  logic [2:0]  W_stat,
   output logic        F_stall,
   output logic        D_stall,
   output logic        W_stall,
   output logic        D_bubble,
   output logic        E_bubble,
   output logic        M_bubble,
   output logic        halted,
   output logic        fault,
   output logic [2:0]  stat_out,
   output logic [31:0] cyc_cnt,
   output logic [31:0] lu_cnt,
   output logic [31:0] mp_cnt,
   output logic [31:0] ret_cnt
);

   localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

   pc_state_e     r_state;
   logic [CW-1:0] r_init_cnt;
   logic [2:0]    r_stat;
   logic          r_halted;
   logic          r_fault;

   logic w_load_use;
   logic w_mispred;
   logic w_ret_in;
   logic w_init;
   logic w_run;

   assign w_load_use = ((E_icode == I_MRMOV) || (E_icode == I_POP))
                     && (E_dstM != REG_NONE)
                     && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign w_mispred  = (E_icode == I_JXX) && !e_Cnd;
   assign w_ret_in   = (D_icode == I_RET) || (E_icode == I_RET)
                     || (M_icode == I_RET);

   assign w_init = (r_state == ST_INIT);
   assign w_run  = (r_state == ST_RUN);

   // A load-use hazard stalls D, so it must win over the ret bubble.
   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      unique case (1'b1)
         w_init: begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
         end
         w_run: begin
            F_stall  = w_load_use || w_ret_in;
            D_stall  = w_load_use;
            D_bubble = w_mispred || (w_ret_in && !w_load_use);
            E_bubble = w_mispred || w_load_use;
            M_bubble = is_exc(m_stat) || is_exc(W_stat);
            W_stall  = is_exc(W_stat);
         end
         default: begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         r_stat     <= STAT_AOK;
         r_halted   <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_init_cnt == INIT_LAST) begin
                  r_state <= ST_RUN;
               end else begin
                  r_init_cnt <= r_init_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (W_stat == STAT_HLT) begin
                  r_state  <= ST_HALTED;
                  r_stat   <= W_stat;
                  r_halted <= 1'b1;
               end else if ((W_stat == STAT_ADR) || (W_stat == STAT_INS)) begin
                  r_state  <= ST_FAULT;
                  r_stat   <= W_stat;
                  r_halted <= 1'b1;
                  r_fault  <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign halted   = r_halted;
   assign fault    = r_fault;
   assign stat_out = r_stat;

`ifdef PIPE_CTRL_PERF_EN
   logic w_inc_lu;
   logic w_inc_mp;
   logic w_inc_ret;

   assign w_inc_lu  = w_run && w_load_use;
   assign w_inc_mp  = w_run && w_mispred;
   assign w_inc_ret = w_run && (D_icode == I_RET) && !w_load_use;

   pipe_sat_cnt u_cyc (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_run),
      .o_cnt (cyc_cnt)
   );

   pipe_sat_cnt u_lu (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc_lu),
      .o_cnt (lu_cnt)
   );

   pipe_sat_cnt u_mp (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc_mp),
      .o_cnt (mp_cnt)
   );

   pipe_sat_cnt u_ret (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc_ret),
      .o_cnt (ret_cnt)
   );
`else
   assign cyc_cnt = '0;
   assign lu_cnt  = '0;
   assign mp_cnt  = '0;
   assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: scoreboarded control vectors per hazard.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [5:0] X_INIT = 6'b101110;
   localparam logic [5:0] X_NONE = 6'b000000;
   localparam logic [5:0] X_LU   = 6'b110100;
   localparam logic [5:0] X_MP   = 6'b001100;
   localparam logic [5:0] X_RET  = 6'b101000;
   localparam logic [5:0] X_EXC  = 6'b000011;
   localparam logic [5:0] X_MEXC = 6'b000010;
   localparam logic [5:0] X_STOP = 6'b110111;

   logic        clk;
   logic        rst_n;
   logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic        e_Cnd;
   logic [2:0]  m_stat, W_stat;
   logic        F_stall, D_stall, W_stall;
   logic        D_bubble, E_bubble, M_bubble;
   logic        halted, fault;
   logic [2:0]  stat_out;
   logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

   pipe_ctrl #(.INIT_CYCLES(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .D_icode  (D_icode),
      .d_srcA   (d_srcA),
      .d_srcB   (d_srcB),
      .E_icode  (E_icode),
      .E_dstM   (E_dstM),
      .e_Cnd    (e_Cnd),
      .M_icode  (M_icode),
      .m_stat   (m_stat),
      .W_stat   (W_stat),
      .F_stall  (F_stall),
      .D_stall  (D_stall),
      .W_stall  (W_stall),
      .D_bubble (D_bubble),
      .E_bubble (E_bubble),
      .M_bubble (M_bubble),
      .halted   (halted),
      .fault    (fault),
      .stat_out (stat_out),
      .cyc_cnt  (cyc_cnt),
      .lu_cnt   (lu_cnt),
      .mp_cnt   (mp_cnt),
      .ret_cnt  (ret_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] di, sa, sb, ei, ed;
      logic       cnd;
      logic [3:0] mi;
      logic [2:0] ms, ws;
      logic [5:0] x;
      logic       lu, mp, rt;
   } row_t;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned e_cyc, e_lu, e_mp, e_ret;
   bit          m_run;
   logic [5:0]  sb[$];
   logic [5:0]  got, exp;

   wire logic [5:0] w_ctrl = {F_stall, D_stall, D_bubble,
                              E_bubble, M_bubble, W_stall};

   function automatic row_t mk(
      input logic [3:0] di, sa, sb_, ei, ed,
      input logic cnd,
      input logic [3:0] mi,
      input logic [2:0] ms, ws,
      input logic [5:0] x,
      input logic lu, mp, rt);
      row_t r;
      r = '{di, sa, sb_, ei, ed, cnd, mi, ms, ws, x, lu, mp, rt};
      return r;
   endfunction

   task automatic drive(input row_t r);
      D_icode = r.di; d_srcA = r.sa; d_srcB = r.sb;
      E_icode = r.ei; E_dstM = r.ed; e_Cnd  = r.cnd;
      M_icode = r.mi; m_stat = r.ms; W_stat = r.ws;
   endtask

   task automatic set_idle();
      drive(mk(1, 15, 15, 1, 15, 0, 1, 1, 1, 0, 0, 0, 0));
   endtask

   task automatic tick(input logic lu, mp, rt);
      if (m_run) begin
         e_cyc++;
         if (lu) e_lu++;
         if (mp) e_mp++;
         if (rt) e_ret++;
      end
      @(negedge clk);
   endtask

   task automatic clr_model();
      e_cyc = 0; e_lu = 0; e_mp = 0; e_ret = 0; m_run = 0;
   endtask

   task automatic test_reset();
      clr_model();
      rst_n = 1'b0;
      set_idle();
      repeat (2) @(negedge clk);
      sb.push_back(X_INIT);
      #1;
      exp = sb.pop_front(); got = w_ctrl; n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL rst_ctrl got=%b exp=%b", got, exp);
      end
      n_tests++;
      if ({halted, fault, stat_out} !== 5'b00001) begin
         n_fail++;
         $display("FAIL rst_stat got=%b exp=00001", {halted, fault, stat_out});
      end
      n_tests++;
      if ((cyc_cnt | lu_cnt | mp_cnt | ret_cnt) !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_cnt got=%h exp=0", cyc_cnt | lu_cnt | mp_cnt | ret_cnt);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sb.push_back(X_INIT);
         #1;
         exp = sb.pop_front(); got = w_ctrl; n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL flush[%0d] got=%b exp=%b", i, got, exp);
         end
         tick(0, 0, 0);
      end
      m_run = 1'b1;
      sb.push_back(X_NONE);
      #1;
      exp = sb.pop_front(); got = w_ctrl; n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL run_idle got=%b exp=%b", got, exp);
      end
      tick(0, 0, 0);
      n_tests++;
      if (cyc_cnt !== (PERF ? 32'(e_cyc) : 32'd0)) begin
         n_fail++;
         $display("FAIL cyc_first got=%0d exp=%0d", cyc_cnt, PERF ? e_cyc : 0);
      end
   endtask

   task automatic test_hazards();
      row_t rows[$];
      rows.push_back(mk(1, 15, 3, 5, 3, 0, 1, 1, 1, X_LU, 1, 0, 0));
      rows.push_back(mk(1, 15, 3, 5, 15, 0, 1, 1, 1, X_NONE, 0, 0, 0));
      rows.push_back(mk(1, 2, 15, 11, 2, 0, 1, 1, 1, X_LU, 1, 0, 0));
      rows.push_back(mk(1, 15, 15, 7, 15, 0, 1, 1, 1, X_MP, 0, 1, 0));
      rows.push_back(mk(1, 15, 15, 7, 15, 1, 1, 1, 1, X_NONE, 0, 0, 0));
      rows.push_back(mk(9, 15, 15, 1, 15, 0, 1, 1, 1, X_RET, 0, 0, 1));
      rows.push_back(mk(1, 15, 15, 9, 15, 0, 1, 1, 1, X_RET, 0, 0, 0));
      rows.push_back(mk(1, 15, 15, 1, 15, 0, 9, 1, 1, X_RET, 0, 0, 0));
      rows.push_back(mk(1, 15, 15, 1, 15, 0, 1, 1, 1, X_NONE, 0, 0, 0));
      rows.push_back(mk(9, 4, 15, 5, 4, 0, 1, 1, 1, X_LU, 1, 0, 0));
      rows.push_back(mk(1, 15, 15, 1, 15, 0, 1, 3, 1, X_MEXC, 0, 0, 0));
      rows.push_back(mk(1, 15, 15, 1, 15, 0, 1, 1, 0, X_NONE, 0, 0, 0));
      rows.push_back(mk(1, 15, 15, 1, 15, 0, 1, 1, 7, X_NONE, 0, 0, 0));
      foreach (rows[i]) begin
         drive(rows[i]);
         sb.push_back(rows[i].x);
         #1;
         exp = sb.pop_front(); got = w_ctrl; n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL hz[%0d] got=%b exp=%b", i, got, exp);
         end
         tick(rows[i].lu, rows[i].mp, rows[i].rt);
      end
      set_idle();
      n_tests++;
      if (halted !== 1'b0) begin
         n_fail++;
         $display("FAIL undef_wstat halted got=%b exp=0", halted);
      end
      n_tests++;
      if ({lu_cnt, mp_cnt, ret_cnt} !== (PERF ? {32'(e_lu), 32'(e_mp), 32'(e_ret)} : 96'd0)) begin
         n_fail++;
         $display("FAIL hz_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                  lu_cnt, mp_cnt, ret_cnt, e_lu, e_mp, e_ret);
      end
   endtask

   task automatic test_halt();
      drive(mk(1, 15, 15, 1, 15, 0, 1, 1, 2, X_EXC, 0, 0, 0));
      sb.push_back(X_EXC);
      #1;
      exp = sb.pop_front(); got = w_ctrl; n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL halt_cycle got=%b exp=%b", got, exp);
      end
      tick(0, 0, 0);
      m_run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(mk(9, 3, 15, 5, 3, 0, 1, 1, 1, X_STOP, 1, 0, 0));
         sb.push_back(X_STOP);
         #1;
         exp = sb.pop_front(); got = w_ctrl; n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL halted_ctrl[%0d] got=%b exp=%b", i, got, exp);
         end
         tick(1, 0, 0);
      end
      n_tests++;
      if ({halted, fault, stat_out} !== 5'b10010) begin
         n_fail++;
         $display("FAIL halt_stat got=%b exp=10010", {halted, fault, stat_out});
      end
      n_tests++;
      if ({cyc_cnt, lu_cnt} !== (PERF ? {32'(e_cyc), 32'(e_lu)} : 64'd0)) begin
         n_fail++;
         $display("FAIL halt_frozen got=%0d/%0d exp=%0d/%0d", cyc_cnt, lu_cnt, e_cyc, e_lu);
      end
   endtask

   task automatic test_fault();
      rst_n = 1'b0;
      set_idle();
      clr_model();
      #1;
      n_tests++;
      if ({w_ctrl, halted, fault} !== {X_INIT, 2'b00}) begin
         n_fail++;
         $display("FAIL halt_rst got=%b exp=%b", {w_ctrl, halted, fault}, {X_INIT, 2'b00});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick(0, 0, 0);
      m_run = 1'b1;
      drive(mk(1, 15, 15, 7, 15, 0, 1, 1, 3, 6'b001111, 0, 1, 0));
      sb.push_back(6'b001111);
      #1;
      exp = sb.pop_front(); got = w_ctrl; n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL fault_cycle got=%b exp=%b", got, exp);
      end
      tick(0, 1, 0);
      m_run = 1'b0;
      set_idle();
      n_tests++;
      if ({halted, fault, stat_out} !== 5'b11011) begin
         n_fail++;
         $display("FAIL fault_stat got=%b exp=11011", {halted, fault, stat_out});
      end
      n_tests++;
      if ({cyc_cnt, mp_cnt} !== (PERF ? {32'(e_cyc), 32'(e_mp)} : 64'd0)) begin
         n_fail++;
         $display("FAIL fault_cnt got=%0d/%0d exp=%0d/%0d", cyc_cnt, mp_cnt, e_cyc, e_mp);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({fault, halted, stat_out, cyc_cnt, mp_cnt} !== {2'b00, 3'd1, 64'd0}) begin
         n_fail++;
         $display("FAIL fault_rst got=%b%b st=%0d cnt=%0d/%0d exp=00 st=1 cnt=0/0",
                  fault, halted, stat_out, cyc_cnt, mp_cnt);
      end
      clr_model();
      @(negedge clk);
   endtask

   task automatic test_reflush();
      rst_n = 1'b1;
      repeat (2) tick(0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(i < 4 ? X_INIT : X_NONE);
         #1;
         exp = sb.pop_front(); got = w_ctrl; n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL reflush[%0d] got=%b exp=%b", i, got, exp);
         end
         tick(0, 0, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clr_model();
      set_idle();
      test_reset();
      test_hazards();
      test_halt();
      test_fault();
      test_reflush();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
